fetch_pc_gen: RTL
=================

Name: fetch_pc_gen

Overview:
- Parametrised front-end PC generator for the superscalar core; successor to the fixed two-slot next-PC logic.
- Each cycle it produces FETCH_WIDTH consecutive instruction addresses for the instruction memory.
- It advances by the number of slots decode actually accepted, so partial acceptance needs no special case.
- Redirect priority, highest first: backend flush, then the oldest decode branch/jal/jalr. A redirect that arrives while memory is not ready is held in a pending register and applied later.

Parameters:
- XLEN, 32, address width.
- FETCH_WIDTH, 2, instructions fetched per cycle (N); must be at least 1.
- RESET_PC, 32'h0001_0000, first fetch address; must be 4-byte aligned.
- CNT_W, $clog2(FETCH_WIDTH+1), width of accept_cnt.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_ready  in  1  instruction memory can take this cycle's fetch group.
- accept_cnt  in  CNT_W  slots of the current group decode accepted (0..N); values above N are treated as N.
- flush_valid  in  1  backend mispredict/exception redirect.
- flush_pc  in  XLEN  flush target.
- redir_valid  in  N  per-slot decode redirect request; slot 0 is oldest.
- redir_type  in  2*N  per slot: 00 none, 01 branch, 10 jal, 11 jalr.
- redir_pc  in  N*XLEN  PC of each redirecting instruction.
- redir_off  in  N*XLEN  sign-extended byte offset, used for branch and jal.
- redir_abs  in  N*XLEN  absolute rs1+imm target, used for jalr.
- fetch_valid  out  1  fetch group is valid.
- fetch_pc  out  N*XLEN  slot i address = pc_base + 4*i.
- redirect_pending  out  1  a redirect is held awaiting fetch_ready.

Behaviour:
- State:
  - pc_base (XLEN).
  - fetch_valid register.
  - pend_valid and pend_target (XLEN).
- Reset (rst=1 at a clock edge):
  - pc_base = RESET_PC.
  - fetch_valid = 0.
  - pend_valid = 0 and redirect_pending = 0.
  - fetch_pc slot i reads RESET_PC + 4*i.
  - rst overrides all other inputs. Asserting rst mid-redirect discards any pending target.
- The first cycle after rst deasserts still shows fetch_valid=0. fetch_valid becomes 1 from the following edge and stays 1 until the next reset.
- Decode target for slot i:
  - type 01 or 10: redir_pc + redir_off.
  - type 11: redir_abs.
  - The two LSBs of the result are forced to 0.
  - Addition is modulo 2^XLEN with no overflow flag.
- Selected decode redirect: the lowest index i with redir_valid[i]=1 and type != 00. Younger slots are ignored. A slot with redir_valid=1 and type 00 is not a redirect.
- Next-state priority, evaluated each edge:
  1. rst: as described above.
  2. flush_valid:
     - pc_base <= flush_pc with the LSBs forced to 00.
     - pend_valid <= 0.
     - Applies regardless of fetch_ready, pending state, or decode redirects.
  3. pend_valid=1 (decode redirect inputs are ignored):
     - If fetch_ready: pc_base <= pend_target and pend_valid <= 0.
     - Otherwise: hold everything.
  4. Decode redirect selected:
     - If fetch_ready: pc_base <= target.
     - Otherwise: pend_target <= target and pend_valid <= 1.
  5. fetch_valid and fetch_ready:
     - pc_base <= pc_base + 4*min(accept_cnt, N).
     - accept_cnt=0 holds the group, which acts as a stall.
     - Partial acceptance restarts the next group at the first unaccepted slot.
  6. Otherwise: hold.
- Latency: every redirect appears on fetch_pc exactly one cycle after the edge at which it is applied.
- accept_cnt is ignored on any edge where a flush or redirect is applied.
- Wrap-around: pc_base and the slot addresses wrap modulo 2^XLEN.
- All outputs are driven from registers plus the slot adders. There is no combinational path from any input to fetch_pc or fetch_valid.

Test Plan:
- Reset/advance (N=2): rst held 2 cycles, then fetch_ready=1 and accept_cnt=2 -> fetch_valid=0 for one cycle, then groups {0x10000,0x10004}, {0x10008,0x1000C}, {0x10010,0x10014}.
- Partial accept: group {0x10008,0x1000C} with accept_cnt=1 -> next group {0x1000C,0x10010}. accept_cnt=0 -> group unchanged. accept_cnt=3 -> treated as 2.
- Oldest-slot priority: slot0 type 01 (pc 0x10020, off 0x40) and slot1 type 11 (abs 0x2000) -> next fetch_pc slot0 = 0x10060. jalr alone with abs 0x3003 -> 0x3000.
- Pending: redirect to 0x4000 while fetch_ready=0 for 3 cycles -> redirect_pending=1, fetch_pc held, new slot redirects ignored. On fetch_ready=1, one cycle later fetch_pc slot0 = 0x4000 and redirect_pending=0.
- Flush priority: flush_pc=0x8002 with a simultaneous decode redirect, pending set, fetch_ready=0 -> fetch_pc slot0 = 0x8000 next cycle and pending cleared.
- Wrap and parameters: pc_base 0xFFFFFFF8 with accept_cnt=2 -> 0x0. Repeat the advance test with FETCH_WIDTH=4 and accept_cnt=3 -> advance by 12.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Front-end PC generator: emits FETCH_WIDTH consecutive fetch addresses per
// cycle. The group advances by the number of slots decode accepted. Redirect
// priority is flush, then a held pending redirect, then the oldest decode
// branch/jal/jalr. A decode redirect that arrives while memory is stalled is
// parked in a pending register until fetch_ready.

// Per-slot logic: the slot fetch address and that slot's decode redirect target.
module fetch_pc_lane #(
  parameter int XLEN = 32,
  parameter int IDX  = 0
) (
  input  logic [XLEN-1:0] pc_base,
  input  logic [1:0]      rtype,
  input  logic [XLEN-1:0] rpc,
  input  logic [XLEN-1:0] roff,
  input  logic [XLEN-1:0] rabs,
  output logic [XLEN-1:0] slot_pc,
  output logic [XLEN-1:0] tgt
);
  logic [XLEN-1:0] raw;

  assign slot_pc = pc_base + XLEN'(4 * IDX);

  // jalr takes the absolute target; branch and jal are pc-relative.
  always_comb begin
    raw = (rtype == 2'b11) ? rabs : (rpc + roff);
    tgt = raw & ~XLEN'(3);
  end
endmodule

module fetch_pc_gen #(
  parameter int          XLEN        = 32,
  parameter int          FETCH_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0001_0000,
  parameter int          CNT_W       = $clog2(FETCH_WIDTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fetch_ready,
  input  logic [CNT_W-1:0]                  accept_cnt,
  input  logic                              flush_valid,
  input  logic [XLEN-1:0]                   flush_pc,
  input  logic [FETCH_WIDTH-1:0]            redir_valid,
  input  logic [FETCH_WIDTH-1:0][1:0]       redir_type,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0]  redir_pc,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0]  redir_off,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0]  redir_abs,
  output logic                              fetch_valid,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0]  fetch_pc,
  output logic                              redirect_pending
);
  logic [XLEN-1:0]                  pc_base, pc_base_nxt;
  logic                             pend_valid, pend_valid_nxt;
  logic [XLEN-1:0]                  pend_target, pend_target_nxt;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] lane_tgt;
  logic                             sel_hit;
  logic [XLEN-1:0]                  sel_tgt;
  logic [CNT_W-1:0]                 acc_clamp;

  genvar g;
  generate
    for (g = 0; g < FETCH_WIDTH; g++) begin : g_lane
      fetch_pc_lane #(.XLEN(XLEN), .IDX(g)) u_lane (
        .pc_base (pc_base),
        .rtype   (redir_type[g]),
        .rpc     (redir_pc[g]),
        .roff    (redir_off[g]),
        .rabs    (redir_abs[g]),
        .slot_pc (fetch_pc[g]),
        .tgt     (lane_tgt[g])
      );
    end
  endgenerate

  assign redirect_pending = pend_valid;

  // Oldest slot wins: scan young to old so the lowest index overwrites last.
  always_comb begin
    sel_hit = 1'b0;
    sel_tgt = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (redir_valid[i] && (redir_type[i] != 2'b00)) begin
        sel_hit = 1'b1;
        sel_tgt = lane_tgt[i];
      end
    end
  end

  // Next-state selection in redirect priority order; accept counts above N saturate.
  always_comb begin
    acc_clamp       = (accept_cnt > CNT_W'(FETCH_WIDTH)) ? CNT_W'(FETCH_WIDTH) : accept_cnt;
    pc_base_nxt     = pc_base;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    if (flush_valid) begin
      pc_base_nxt    = flush_pc & ~XLEN'(3);
      pend_valid_nxt = 1'b0;
    end else if (pend_valid) begin
      if (fetch_ready) begin
        pc_base_nxt    = pend_target;
        pend_valid_nxt = 1'b0;
      end
    end else if (sel_hit) begin
      if (fetch_ready) begin
        pc_base_nxt = sel_tgt;
      end else begin
        pend_target_nxt = sel_tgt;
        pend_valid_nxt  = 1'b1;
      end
    end else if (fetch_valid && fetch_ready) begin
      pc_base_nxt = pc_base + (XLEN'(acc_clamp) << 2);
    end
  end

  // State registers; fetch_valid rises on the first edge after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_base     <= XLEN'(RESET_PC);
      fetch_valid <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      pc_base     <= pc_base_nxt;
      fetch_valid <= 1'b1;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
    end
  end
endmodule
